// File: rtl/count_ctrl.sv
// count_ctrl: run-control sequencer for a count_n prescaled up/down counter.
// Define COUNT_CTRL_BOUNCE_EN to ping-pong between 0 and LIMIT instead of stopping in DONE.
module count_ctrl #(
  parameter int M     = 4,
  parameter int LIMIT = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_btn,
  input  logic         stop_btn,
  input  logic         clr_btn,
  input  logic         dir_sw,
  input  logic [M-1:0] cnt_val,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         cnt_clr,
  output logic         running,
  output logic         done,
  output logic         tc_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE,
    CLEAR
  } state_e;

  localparam logic [M-1:0] LIMIT_VAL = M'(LIMIT);

  // Button bit order: [0] start, [1] stop, [2] clear.
  logic [2:0] btnMeta_q;
  logic [2:0] btnSync_q;
  logic [2:0] btnPrev_q;
  logic [2:0] armed_q;
  logic       dirMeta_q;
  logic       dirSync_q;

  state_e     state_q;
  state_e     stateD;
  logic       cntUp_q;
  logic       cntUpD;
  logic       tcD;
  logic       cntEn_q;
  logic       cntClr_q;
  logic       running_q;
  logic       done_q;
  logic       tcPulse_q;

  logic [2:0] cmd;
  logic       startCmd;
  logic       stopCmd;
  logic       clrCmd;
  logic       term;

  // armed_q fills with ones after reset so that a button already held at
  // release (whose prev flop never saw a real low sample) is not taken as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnMeta_q <= '0;
      btnSync_q <= '0;
      btnPrev_q <= '0;
      armed_q   <= '0;
      dirMeta_q <= 1'b0;
      dirSync_q <= 1'b0;
    end else begin
      btnMeta_q <= {clr_btn, stop_btn, start_btn};
      btnSync_q <= btnMeta_q;
      btnPrev_q <= btnSync_q;
      armed_q   <= {armed_q[1:0], 1'b1};
      dirMeta_q <= dir_sw;
      dirSync_q <= dirMeta_q;
    end
  end

  assign cmd      = btnSync_q & ~btnPrev_q & {3{armed_q[2]}};
  assign startCmd = cmd[0];
  assign stopCmd  = cmd[1];
  assign clrCmd   = cmd[2];

  assign term = cntUp_q ? (cnt_val == LIMIT_VAL) : (cnt_val == '0);

  always_comb begin
    stateD = state_q;
    cntUpD = cntUp_q;
    tcD    = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        if (clrCmd) begin
          stateD = CLEAR;
        end else if (startCmd) begin
          stateD = RUN;
          cntUpD = dirSync_q;
        end
      end
      RUN: begin
        if (clrCmd) begin
          stateD = CLEAR;
        end else if (stopCmd) begin
          stateD = PAUSE;
        end else if (term) begin
          tcD = 1'b1;
`ifdef COUNT_CTRL_BOUNCE_EN
          cntUpD = ~cntUp_q;
`else
          stateD = DONE;
`endif
        end
      end
      DONE: begin
        if (clrCmd) begin
          stateD = CLEAR;
        end
      end
      CLEAR:   stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cntUp_q   <= 1'b1;
      cntEn_q   <= 1'b0;
      cntClr_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tcPulse_q <= 1'b0;
    end else begin
      state_q   <= stateD;
      cntUp_q   <= cntUpD;
      cntEn_q   <= (stateD == RUN);
      cntClr_q  <= (stateD == CLEAR);
      running_q <= (stateD == RUN);
      done_q    <= (stateD == DONE);
      tcPulse_q <= tcD;
    end
  end

  assign cnt_en   = cntEn_q;
  assign cnt_up   = cntUp_q;
  assign cnt_clr  = cntClr_q;
  assign running  = running_q;
  assign done     = done_q;
  assign tc_pulse = tcPulse_q;

endmodule
